// File: rtl/sort_ctrl.sv
// rtl/sort_ctrl.sv - packet buffer and command sequencer wrapped around the sorter stage
// Buffers one sink packet, drives the sorter's load/sort/read-out/clear commands and re-emits the result.
module sort_ctrl #(
    parameter int DWIDTH       = 8,
    parameter int AWIDTH       = 4,
    parameter int SORT_TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic              srt_wren_o,
    output logic              srt_sort_op_o,
    output logic              srt_output_op_o,
    output logic              srt_clear_op_o,
    output logic [AWIDTH-1:0] srt_cntr_o,
    output logic [DWIDTH-1:0] srt_data_o,
    input  logic [AWIDTH-1:0] srt_rdaddr_i,
    input  logic              srt_sort_done_i,
    input  logic [DWIDTH-1:0] srt_data_i,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              err_o
);

    localparam int DEPTH = 2**AWIDTH;
    localparam int WDW   = $clog2(SORT_TIMEOUT + 1);
    localparam logic [AWIDTH-1:0] MAXLEN = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH-1:0] A_ONE  = AWIDTH'(1);
    localparam logic [WDW-1:0]    WD_ONE = WDW'(1);
    localparam logic [WDW-1:0]    WD_TMO = WDW'(SORT_TIMEOUT);
    localparam logic [WDW-1:0]    WD_PRE = WDW'(SORT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RECV,
        S_SORT,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   len_q, len_d;
    logic [AWIDTH-1:0]   ops_q, ops_d;
    logic [AWIDTH-1:0]   caps_q, caps_d;
    logic [WDW-1:0]      wd_q, wd_d;
    logic                err_q, err_d;
    logic                cap_q, cap_d;
    logic [DWIDTH-1:0]   src_data_q, src_data_d;
    logic                src_valid_q, src_valid_d;
    logic                src_sop_q, src_sop_d;
    logic                src_eop_q, src_eop_d;

    logic [DWIDTH-1:0]   buf_mem [DEPTH];

    logic                snk_ready;
    logic                snk_xfer;
    logic                store;
    logic [AWIDTH-1:0]   wr_addr;
    logic                src_xfer;
    logic                issue;

    always_comb begin
        snk_ready = (state_q == S_IDLE) || (state_q == S_RECV);
        snk_xfer  = snk_valid_i && snk_ready;
        store     = 1'b0;
        if (state_q == S_IDLE) begin
            store = snk_xfer && snk_startofpacket_i;
        end else if (state_q == S_RECV) begin
            store = snk_xfer && (snk_startofpacket_i || (len_q != MAXLEN));
        end
        wr_addr  = snk_startofpacket_i ? '0 : len_q;
        src_xfer = src_valid_q && src_ready_i;
        // cap_q marks an op issued last cycle; spacing ops keeps the capture slot free.
        issue    = (state_q == S_DRAIN) && !cap_q && (ops_q != len_q)
                   && (!src_valid_q || src_ready_i);
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ops_d       = ops_q;
        caps_d      = caps_q;
        wd_d        = wd_q;
        err_d       = 1'b0;
        cap_d       = issue;
        src_data_d  = src_data_q;
        src_valid_d = src_valid_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;

        if (src_xfer) begin
            src_valid_d = 1'b0;
            src_sop_d   = 1'b0;
            src_eop_d   = 1'b0;
        end
        if (cap_q) begin
            src_data_d  = srt_data_i;
            src_valid_d = 1'b1;
            src_sop_d   = (caps_q == '0);
            src_eop_d   = ((caps_q + A_ONE) == len_q);
            caps_d      = caps_q + A_ONE;
        end
        if (issue) begin
            ops_d = ops_q + A_ONE;
        end

        case (state_q)
            S_CLEAR: begin
                state_d = S_IDLE;
                len_d   = '0;
                ops_d   = '0;
                caps_d  = '0;
                wd_d    = '0;
            end
            S_IDLE: begin
                if (store) begin
                    len_d = A_ONE;
                    wd_d  = '0;
                    state_d = snk_endofpacket_i ? S_SORT : S_RECV;
                end
            end
            S_RECV: begin
                if (snk_xfer) begin
                    if (snk_startofpacket_i) begin
                        len_d = A_ONE;
                    end else if (len_q != MAXLEN) begin
                        len_d = len_q + A_ONE;
                    end
                    if (snk_endofpacket_i) begin
                        state_d = S_SORT;
                        wd_d    = '0;
                    end
                end
            end
            S_SORT: begin
                // err_o is high in the cycle the watchdog sits at the limit; the clear follows.
                if (wd_q == WD_TMO) begin
                    state_d = S_CLEAR;
                    len_d   = '0;
                end else if (srt_sort_done_i) begin
                    state_d = S_DRAIN;
                end else begin
                    wd_d  = wd_q + WD_ONE;
                    err_d = (wd_q == WD_PRE);
                end
            end
            S_DRAIN: begin
                if (src_xfer && src_eop_q) begin
                    state_d = S_CLEAR;
                    len_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_CLEAR;
            len_q       <= '0;
            ops_q       <= '0;
            caps_q      <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            cap_q       <= 1'b0;
            src_data_q  <= '0;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ops_q       <= ops_d;
            caps_q      <= caps_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
            src_data_q  <= src_data_d;
            src_valid_q <= src_valid_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) begin
            buf_mem[wr_addr] <= snk_data_i;
        end
    end

    assign snk_ready_o         = snk_ready;
    assign srt_wren_o          = store;
    assign srt_sort_op_o       = (state_q == S_SORT);
    assign srt_output_op_o     = issue;
    // Gated by rst_i so the clear pulse lands in the first cycle after release, not during reset.
    assign srt_clear_op_o      = (state_q == S_CLEAR) && !rst_i;
    assign srt_cntr_o          = len_q;
    assign srt_data_o          = (srt_rdaddr_i < len_q) ? buf_mem[srt_rdaddr_i] : '0;
    assign src_data_o          = src_data_q;
    assign src_startofpacket_o = src_sop_q;
    assign src_endofpacket_o   = src_eop_q;
    assign src_valid_o         = src_valid_q;
    assign err_o               = err_q;

endmodule
